// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for alu_share_arbiter.
// The arbiter takes the slave modport; the environment (requesters plus the
// shared ALU) takes the master modport.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic [3:0]       rsp0_flags;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic [3:0]       rsp1_flags;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_cntrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_negative;
  logic             alu_carry;
  logic             alu_over_flow;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_flags,
    output rsp1_valid, rsp1_result, rsp1_flags,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_cntrl,
    input  alu_result, alu_negative, alu_carry, alu_over_flow
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_flags,
    input  rsp1_valid, rsp1_result, rsp1_flags,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_cntrl,
    output alu_result, alu_negative, alu_carry, alu_over_flow
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters.
// One operation in flight at a time: IDLE accepts, EXEC lets the ALU settle
// on registered operands, RESP holds the captured result until it is taken.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;   // id served most recently; reset to 1 so the first tie goes to req0
  logic             id_q, id_d;       // owner of the operation in flight
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_ready;
  logic             grant;
  logic             capture;          // end of EXEC: load the owner's response register
  logic             rsp_done;         // owner's response taken this edge

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b10) begin
      grant = 1'b1;
    end else if (req_valid == 2'b11) begin
      grant = ~last_q;
    end
  end

  // State, pointer and operand registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  // Next state, handshake and operand latching
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    req_ready = '0;
    capture   = 1'b0;
    rsp_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid[grant]) begin
          req_ready[grant] = 1'b1;
          id_d    = grant;
          a_d     = grant ? bus.req1_a  : bus.req0_a;
          b_d     = grant ? bus.req1_b  : bus.req0_b;
          op_d    = grant ? bus.req1_op : bus.req0_op;
          state_d = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[id_q]) begin
          rsp_done = 1'b1;
          last_d   = id_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];

  // The ALU always sees the latched operation, so it is stable through EXEC and RESP
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_cntrl = op_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      localparam logic MY_ID = 1'(gi);
      logic             valid_q;
      logic [WIDTH-1:0] result_q;
      logic [3:0]       flags_q;

      // Capture result and {zero, negative, carry, over_flow}; hold until the requester takes it
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q  <= 1'b0;
          result_q <= '0;
          flags_q  <= '0;
        end else if (capture && (id_q == MY_ID)) begin
          valid_q  <= 1'b1;
          result_q <= bus.alu_result;
          flags_q  <= {(bus.alu_result == '0), bus.alu_negative, bus.alu_carry, bus.alu_over_flow};
        end else if (rsp_done && (id_q == MY_ID)) begin
          valid_q  <= 1'b0;
        end
      end
    end
  endgenerate

  assign bus.rsp0_valid  = g_rsp[0].valid_q;
  assign bus.rsp0_result = g_rsp[0].result_q;
  assign bus.rsp0_flags  = g_rsp[0].flags_q;
  assign bus.rsp1_valid  = g_rsp[1].valid_q;
  assign bus.rsp1_result = g_rsp[1].result_q;
  assign bus.rsp1_flags  = g_rsp[1].flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: queued requesters, a behavioural ALU and a
// transaction-level model of who is served, when, and with what response.
module tb_alu_share_arbiter;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
  } op_t;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(W)) bus ();

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference ALU: returns {zero, negative, carry, over_flow, result}
  function automatic logic [W+3:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b001: begin
        s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b101: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: r = '0;
    endcase
    return {(r == '0), r[W-1], c, v, r};
  endfunction

  // The shared ALU as seen by the arbiter
  logic [W+3:0] alu_x;
  assign alu_x             = alu_ref(bus.alu_a, bus.alu_b, bus.alu_cntrl);
  assign bus.alu_result    = alu_x[W-1:0];
  assign bus.alu_negative  = alu_x[W+2];
  assign bus.alu_carry     = alu_x[W+1];
  assign bus.alu_over_flow = alu_x[W];

  int checks = 0;
  int errors = 0;
  int cyc_num = 0;

  op_t pend0[$];
  op_t pend1[$];

  // Transaction-level model
  logic         m_busy;
  logic         m_id;
  logic         m_last;
  int           m_cyc;     // edges since the accepting edge
  op_t          m_op;
  logic [W+3:0] m_exp;
  int           bp_mode;   // response hold-off per op; negative picks a random one
  int           cur_bp;

  logic [W-1:0] last_res [2];
  logic [3:0]   last_flags [2];
  int           served[$];
  int           hs_cyc[$];

  function automatic op_t rand_op();
    op_t o;
    o.a  = $urandom;
    o.b  = $urandom;
    o.op = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) o.b = o.a;
    return o;
  endfunction

  task automatic drive_inputs();
    bus.req0_valid = (pend0.size() != 0);
    bus.req0_a     = (pend0.size() != 0) ? pend0[0].a  : '0;
    bus.req0_b     = (pend0.size() != 0) ? pend0[0].b  : '0;
    bus.req0_op    = (pend0.size() != 0) ? pend0[0].op : '0;
    bus.req1_valid = (pend1.size() != 0);
    bus.req1_a     = (pend1.size() != 0) ? pend1[0].a  : '0;
    bus.req1_b     = (pend1.size() != 0) ? pend1[0].b  : '0;
    bus.req1_op    = (pend1.size() != 0) ? pend1[0].op : '0;
    bus.rsp0_ready = !m_busy || (m_cyc >= 2 + cur_bp);
    bus.rsp1_ready = !m_busy || (m_cyc >= 2 + cur_bp);
  endtask

  task automatic model_clear();
    pend0.delete();
    pend1.delete();
    m_busy = 1'b0;
    m_last = 1'b1;
    m_id   = 1'b0;
    m_cyc  = 0;
    cur_bp = 0;
  endtask

  // One clock: check at the falling edge, advance the model after the rising edge
  task automatic step();
    logic         e_r0, e_r1, e_v0, e_v1, take;
    logic [W-1:0] rr;
    logic [3:0]   rf;
    @(negedge clk);
    e_r0 = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
    e_r1 = !m_busy && bus.req1_valid && (!bus.req0_valid || !m_last);
    e_v0 = m_busy && (m_cyc >= 2) && !m_id;
    e_v1 = m_busy && (m_cyc >= 2) && m_id;
    checks++;
    if (bus.req0_ready !== e_r0) begin
      errors++;
      $display("FAIL req0_ready cyc=%0d got=%b exp=%b", cyc_num, bus.req0_ready, e_r0);
    end
    checks++;
    if (bus.req1_ready !== e_r1) begin
      errors++;
      $display("FAIL req1_ready cyc=%0d got=%b exp=%b", cyc_num, bus.req1_ready, e_r1);
    end
    checks++;
    if (bus.rsp0_valid !== e_v0) begin
      errors++;
      $display("FAIL rsp0_valid cyc=%0d got=%b exp=%b", cyc_num, bus.rsp0_valid, e_v0);
    end
    checks++;
    if (bus.rsp1_valid !== e_v1) begin
      errors++;
      $display("FAIL rsp1_valid cyc=%0d got=%b exp=%b", cyc_num, bus.rsp1_valid, e_v1);
    end
    if (m_busy) begin
      checks++;
      if ({bus.alu_a, bus.alu_b, bus.alu_cntrl} !== {m_op.a, m_op.b, m_op.op}) begin
        errors++;
        $display("FAIL alu_drive cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc_num,
                 bus.alu_a, bus.alu_b, bus.alu_cntrl, m_op.a, m_op.b, m_op.op);
      end
    end
    rr = m_id ? bus.rsp1_result : bus.rsp0_result;
    rf = m_id ? bus.rsp1_flags  : bus.rsp0_flags;
    if (m_busy && m_cyc >= 2) begin
      checks++;
      if ({rf, rr} !== m_exp) begin
        errors++;
        $display("FAIL rsp%0d_payload cyc=%0d got=%b/%h exp=%b/%h", m_id, cyc_num,
                 rf, rr, m_exp[W+3:W], m_exp[W-1:0]);
      end
    end
    take = m_busy && (m_cyc >= 2) && (m_id ? bus.rsp1_ready : bus.rsp0_ready);
    if (take) begin
      last_res[m_id]   = rr;
      last_flags[m_id] = rf;
      $display("cyc=%0d rsp%0d op=%b a=%h b=%h result=%h flags=%b", cyc_num, m_id,
               m_op.op, m_op.a, m_op.b, rr, rf);
    end
    @(posedge clk);
    cyc_num++;
    #1;
    if (take) begin
      m_busy = 1'b0;
      m_last = m_id;
    end else if (m_busy) begin
      m_cyc++;
    end
    if (e_r0 || e_r1) begin
      m_id   = e_r1;
      m_op   = e_r1 ? pend1.pop_front() : pend0.pop_front();
      m_exp  = alu_ref(m_op.a, m_op.b, m_op.op);
      m_busy = 1'b1;
      m_cyc  = 1;
      cur_bp = (bp_mode < 0) ? int'($urandom_range(0, 3)) : bp_mode;
      served.push_back(int'(e_r1));
      hs_cyc.push_back(cyc_num);
    end
    drive_inputs();
  endtask

  task automatic run_until_idle(input int bound);
    int n;
    n = 0;
    while ((m_busy || pend0.size() != 0 || pend1.size() != 0) && n < bound) begin
      step();
      n++;
    end
    step();
    checks++;
    if (m_busy || pend0.size() != 0 || pend1.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=busy%0b/q%0d/q%0d exp=idle within %0d cycles",
               m_busy, pend0.size(), pend1.size(), bound);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    bp_mode = 0;
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_handshake got=%b exp=0000",
               {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid});
    end
    checks++;
    if ({bus.rsp0_result, bus.rsp0_flags, bus.rsp1_result, bus.rsp1_flags} !== '0) begin
      errors++;
      $display("FAIL reset_rsp got=%h/%b/%h/%b exp=0", bus.rsp0_result, bus.rsp0_flags,
               bus.rsp1_result, bus.rsp1_flags);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_cntrl} !== '0) begin
      errors++;
      $display("FAIL reset_alu got=%h/%h/%b exp=0", bus.alu_a, bus.alu_b, bus.alu_cntrl);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_inputs();
  endtask

  task automatic test_single();
    served.delete();
    pend0.push_back('{a: 32'd5, b: 32'd7, op: 3'b000});
    drive_inputs();
    run_until_idle(10);
    checks++;
    if (served.size() != 1 || last_res[0] !== 32'd12 || last_flags[0] !== 4'b0000) begin
      errors++;
      $display("FAIL single_add got=n%0d/%h/%b exp=n1/0000000c/0000", served.size(),
               last_res[0], last_flags[0]);
    end
  endtask

  task automatic test_sub_zero();
    pend1.push_back('{a: 32'd3, b: 32'd3, op: 3'b001});
    drive_inputs();
    run_until_idle(10);
    checks++;
    if (last_res[1] !== 32'd0 || last_flags[1] !== 4'b1010) begin
      errors++;
      $display("FAIL sub_zero got=%h/%b exp=00000000/1010", last_res[1], last_flags[1]);
    end
  endtask

  task automatic test_undefined_op();
    pend0.push_back('{a: 32'h1234, b: 32'h5678, op: 3'b111});
    drive_inputs();
    run_until_idle(10);
    checks++;
    if (last_res[0] !== 32'd0 || last_flags[0] !== 4'b1000) begin
      errors++;
      $display("FAIL undefined_op got=%h/%b exp=00000000/1000", last_res[0], last_flags[0]);
    end
  endtask

  task automatic test_tie();
    served.delete();
    pend0.push_back('{a: 32'hF0, b: 32'h3C, op: 3'b010});
    pend1.push_back('{a: 32'hFF, b: 32'h0F, op: 3'b010});
    drive_inputs();
    run_until_idle(20);
    checks++;
    if (served.size() != 2 || served[0] != 0 || served[1] != 1) begin
      errors++;
      $display("FAIL tie_order got=n%0d first=%0d exp=n2 first=0", served.size(),
               (served.size() != 0) ? served[0] : -1);
    end
    checks++;
    if (last_res[0] !== 32'h30 || last_res[1] !== 32'h0F) begin
      errors++;
      $display("FAIL tie_results got=%h/%h exp=00000030/0000000f", last_res[0], last_res[1]);
    end
  endtask

  task automatic test_contention();
    int bad_order;
    int bad_gap;
    served.delete();
    hs_cyc.delete();
    bp_mode = 0;
    for (int i = 0; i < 4; i++) begin
      pend0.push_back(rand_op());
      pend1.push_back(rand_op());
    end
    drive_inputs();
    run_until_idle(40);
    bad_order = 0;
    bad_gap   = 0;
    for (int i = 0; i < served.size(); i++) begin
      if (served[i] != (i % 2)) bad_order++;
      if (i > 0 && (hs_cyc[i] - hs_cyc[i-1]) != 3) bad_gap++;
    end
    checks++;
    if (served.size() != 8 || bad_order != 0) begin
      errors++;
      $display("FAIL contention_alternate got=n%0d bad=%0d exp=n8 bad=0", served.size(), bad_order);
    end
    checks++;
    if (bad_gap != 0) begin
      errors++;
      $display("FAIL contention_throughput got=%0d gaps!=3 exp=0", bad_gap);
    end
  endtask

  task automatic test_backpressure();
    served.delete();
    hs_cyc.delete();
    bp_mode = 5;
    pend1.push_back(rand_op());
    drive_inputs();
    step();
    pend0.push_back(rand_op());
    drive_inputs();
    run_until_idle(40);
    checks++;
    if (served.size() != 2 || served[0] != 1 || served[1] != 0) begin
      errors++;
      $display("FAIL backpressure_order got=n%0d exp=n2 order 1,0", served.size());
    end
    checks++;
    if (hs_cyc.size() != 2 || (hs_cyc[1] - hs_cyc[0]) != 8) begin
      errors++;
      $display("FAIL backpressure_gap got=%0d exp=8",
               (hs_cyc.size() == 2) ? hs_cyc[1] - hs_cyc[0] : -1);
    end
    bp_mode = 0;
  endtask

  task automatic test_random();
    bp_mode = -1;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 0) pend0.push_back(rand_op());
      else                           pend1.push_back(rand_op());
    end
    drive_inputs();
    run_until_idle(120);
    bp_mode = 0;
    cur_bp  = 0;
  endtask

  task automatic test_reset_exec();
    served.delete();
    pend0.push_back(rand_op());
    drive_inputs();
    step();
    // Accepted at the last edge: the block is in EXEC now
    reset = 1'b1;
    model_clear();
    drive_inputs();
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 4'b0 ||
        {bus.rsp0_result, bus.rsp0_flags, bus.rsp1_result, bus.rsp1_flags} !== '0 ||
        {bus.alu_a, bus.alu_b, bus.alu_cntrl} !== '0) begin
      errors++;
      $display("FAIL reset_exec_outputs got=%b/%h/%h exp=0",
               {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid},
               bus.rsp0_result, bus.alu_a);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_inputs();
    repeat (4) step();
    served.delete();
    pend0.push_back(rand_op());
    pend1.push_back(rand_op());
    drive_inputs();
    run_until_idle(20);
    checks++;
    if (served.size() != 2 || served[0] != 0) begin
      errors++;
      $display("FAIL reset_exec_tie got=n%0d first=%0d exp=n2 first=0", served.size(),
               (served.size() != 0) ? served[0] : -1);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single();
    test_sub_zero();
    test_undefined_op();
    test_reset();
    test_tie();
    test_contention();
    test_backpressure();
    test_random();
    test_reset_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
